fwd_hazard_unit: RTL

Parametrised forwarding and hazard unit for the pipelined ARM core, replacing the fixed two-stage, two-source forwarding logic. It tracks the destination tags of instructions leaving EXE through DEPTH downstream stages (MEM, WB, …), drives per-source forwarding selects for the EXE operand muxes, and raises a load-use / no-forwarding stall towards the IF/ID stages. A saturating stall counter supports performance checks.

---
 rtl/fwd_hazard_unit_if.sv | 34 +++
 rtl/fwd_hazard_unit.sv | 94 +++++++++
 2 files changed

// File: rtl/fwd_hazard_unit_if.sv
// Operand-tag bundle between the EXE/ID stages and fwd_hazard_unit.
// exe_valid qualifies the EXE fields each cycle; there is no ready: the unit never back-pressures.
interface fwd_hazard_unit_if #(
    parameter int REG_AW  = 4,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2,
    parameter int SEL_W   = $clog2(DEPTH + 1),
    parameter int CNT_W   = 16
);
    logic                      en_forwarding;
    logic                      exe_valid;
    logic                      exe_wb_en;
    logic                      exe_mem_read;
    logic [REG_AW-1:0]         exe_dest;
    logic [NUM_SRC*REG_AW-1:0] exe_src;
    logic [NUM_SRC-1:0]        exe_src_used;
    logic [NUM_SRC*REG_AW-1:0] id_src;
    logic [NUM_SRC-1:0]        id_src_used;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
    logic                      hazard_stall;
    logic [CNT_W-1:0]          stall_count;

    modport master (
        output en_forwarding, exe_valid, exe_wb_en, exe_mem_read, exe_dest,
               exe_src, exe_src_used, id_src, id_src_used,
        input  fwd_sel, hazard_stall, stall_count
    );

    modport slave (
        input  en_forwarding, exe_valid, exe_wb_en, exe_mem_read, exe_dest,
               exe_src, exe_src_used, id_src, id_src_used,
        output fwd_sel, hazard_stall, stall_count
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Tracks destination tags DEPTH stages past EXE, picks per-source forwarding selects
// and raises the load-use / stall-only hazard with a saturating stall counter.
module fwd_hazard_unit #(
    parameter int REG_AW  = 4,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2,
    parameter int SEL_W   = $clog2(DEPTH + 1),
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    fwd_hazard_unit_if.slave bus,
    output logic             fwd_from_load_o
);
    logic [DEPTH:1]             tag_valid_q, tag_valid_d;
    logic [DEPTH:1][REG_AW-1:0] tag_dest_q, tag_dest_d;
    // Only stage 1 can hold a load that matters (forwarding a load from stage 1 is illegal).
    logic                       tag_load_q, tag_load_d;
    logic [CNT_W-1:0]           stall_cnt_q, stall_cnt_d;
    logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
    logic                       exe_prod;
    logic                       id_match;
    logic                       stall;

    always_comb begin
        tag_valid_d[1] = bus.exe_valid & bus.exe_wb_en;
        tag_dest_d[1]  = bus.exe_dest;
        tag_load_d     = bus.exe_mem_read;
        for (int k = 2; k <= DEPTH; k++) begin
            tag_valid_d[k] = tag_valid_q[k-1];
            tag_dest_d[k]  = tag_dest_q[k-1];
        end
    end

    // Scanning from the oldest stage down lets the youngest producer overwrite the select.
    always_comb begin
        fwd_sel         = '0;
        fwd_from_load_o = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.en_forwarding && bus.exe_src_used[i]) begin
                for (int k = DEPTH; k >= 1; k--) begin
                    if (tag_valid_q[k] && (tag_dest_q[k] == bus.exe_src[i*REG_AW +: REG_AW])) begin
                        fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
                    end
                end
                if (tag_valid_q[1] && tag_load_q &&
                    (tag_dest_q[1] == bus.exe_src[i*REG_AW +: REG_AW])) begin
                    fwd_from_load_o = 1'b1;
                end
            end
        end
    end

    always_comb begin
        exe_prod = bus.exe_valid & bus.exe_wb_en;
        id_match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.id_src_used[i] && (bus.id_src[i*REG_AW +: REG_AW] == bus.exe_dest)) begin
                id_match = 1'b1;
            end
        end
        // Stage DEPTH is left out: the register file writes it on the falling edge.
        if (bus.en_forwarding) begin
            stall = exe_prod & bus.exe_mem_read & id_match;
        end else begin
            stall = (exe_prod & id_match) | (|tag_valid_q[DEPTH-1:1]);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_q <= '0;
            tag_dest_q  <= '0;
            tag_load_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_dest_q  <= tag_dest_d;
            tag_load_q  <= tag_load_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.fwd_sel      = fwd_sel;
    assign bus.hazard_stall = stall;
    assign bus.stall_count  = stall_cnt_q;
endmodule
